// File: rtl/instr_fetch_pkg.sv
// Shared types and widths for the instruction fetch unit.
package instr_fetch_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned ADDR_W  = 64;

    typedef enum logic [1:0] {
        BR_SEQ  = 2'b00,
        BR_REL  = 2'b01,
        BR_REG  = 2'b10,
        BR_RSVD = 2'b11
    } br_sel_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        HOLD  = 2'b10,
        ERR   = 2'b11
    } fetch_state_e;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection: sequential, PC-relative branch, or register target.
module pc_next_calc
    import instr_fetch_pkg::*;
(
    input  logic [ADDR_W-1:0]  pc_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [1:0]         br_taken_i,
    input  logic               uncond_br_i,
    input  logic [ADDR_W-1:0]  reg_target_i,
    output logic [ADDR_W-1:0]  next_pc_o
);

    logic [ADDR_W-1:0] offset;
    logic              unused_bits;

    assign unused_bits = ^{instr_i[31:26], instr_i[4:0], reg_target_i[1:0]};

    always_comb begin
        offset    = '0;
        next_pc_o = pc_i + ADDR_W'(4);
        // imm26 for B/BL, imm19 for conditional branches; both are word offsets
        if (uncond_br_i) begin
            offset = {{(ADDR_W-26){instr_i[25]}}, instr_i[25:0]};
        end else begin
            offset = {{(ADDR_W-19){instr_i[23]}}, instr_i[23:5]};
        end
        case (br_sel_e'(br_taken_i))
            BR_REL:  next_pc_o = pc_i + (offset << 2);
            BR_REG:  next_pc_o = {reg_target_i[ADDR_W-1:2], 2'b00};
            default: next_pc_o = pc_i + ADDR_W'(4);
        endcase
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch FSM: requests a word, holds it for decode, then steps the PC.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC     = 64'h0,
    parameter int unsigned IMEM_TIMEOUT = 8
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imemReq,
    output logic [ADDR_W-1:0]  imemAddr,
    input  logic               imemAck,
    input  logic [INSTR_W-1:0] imemRdata,
    output logic [INSTR_W-1:0] instr,
    output logic               instrValid,
    input  logic               instrAccept,
    output logic [ADDR_W-1:0]  pcOut,
    output logic [ADDR_W-1:0]  pcPlus4,
    input  logic [1:0]         brTaken,
    input  logic               uncondBr,
    input  logic [ADDR_W-1:0]  regTarget,
    output logic               fetchErr
);

    localparam int unsigned CNT_W = $clog2(IMEM_TIMEOUT + 1);

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d, next_pc;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    pc_next_calc u_pc_next_calc (
        .pc_i         (pc_q),
        .instr_i      (instr_q),
        .br_taken_i   (brTaken),
        .uncond_br_i  (uncondBr),
        .reg_target_i (regTarget),
        .next_pc_o    (next_pc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
                cnt_d   = '0;
            end
            FETCH: begin
                if (imemAck) begin
                    instr_d = imemRdata;
                    state_d = HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(IMEM_TIMEOUT - 1)) begin
                        state_d = ERR;
                    end
                end
            end
            HOLD: begin
                if (instrAccept) begin
                    pc_d    = next_pc;
                    state_d = FETCH;
                    cnt_d   = '0;
                end
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decodes of registered state
    assign imemReq    = (state_q == FETCH);
    assign imemAddr   = pc_q;
    assign instr      = instr_q;
    assign instrValid = (state_q == HOLD);
    assign pcOut      = pc_q;
    assign pcPlus4    = pc_q + ADDR_W'(4);
    assign fetchErr   = (state_q == ERR);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        imemReq;
    logic [63:0] imemAddr;
    logic        imemAck;
    logic [31:0] imemRdata;
    logic [31:0] instr;
    logic        instrValid;
    logic        instrAccept;
    logic [63:0] pcOut;
    logic [63:0] pcPlus4;
    logic [1:0]  brTaken;
    logic        uncondBr;
    logic [63:0] regTarget;
    logic        fetchErr;

    int n_checks = 0;
    int n_pass   = 0;

    instr_fetch #(.RESET_PC(64'h0), .IMEM_TIMEOUT(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .imemReq     (imemReq),
        .imemAddr    (imemAddr),
        .imemAck     (imemAck),
        .imemRdata   (imemRdata),
        .instr       (instr),
        .instrValid  (instrValid),
        .instrAccept (instrAccept),
        .pcOut       (pcOut),
        .pcPlus4     (pcPlus4),
        .brTaken     (brTaken),
        .uncondBr    (uncondBr),
        .regTarget   (regTarget),
        .fetchErr    (fetchErr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input int budget);
        int n = 0;
        while (!imemReq && n < budget) begin
            tick();
            n++;
        end
    endtask

    // Serve one fetch with a same-cycle ack and check the resulting HOLD state
    task automatic do_fetch(input string tag, input logic [63:0] addr, input logic [31:0] word);
        wait_req(4);
        check({tag, "_req"}, 64'(imemReq), 64'd1);
        check({tag, "_addr"}, imemAddr, addr);
        check({tag, "_p4f"}, pcPlus4, addr + 64'd4);
        imemAck   = 1'b1;
        imemRdata = word;
        tick();
        imemAck   = 1'b0;
        imemRdata = 32'h0;
        check({tag, "_valid"}, 64'(instrValid), 64'd1);
        check({tag, "_noreq"}, 64'(imemReq), 64'd0);
        check({tag, "_instr"}, 64'(instr), 64'(word));
        check({tag, "_pc"}, pcOut, addr);
        check({tag, "_p4h"}, pcPlus4, addr + 64'd4);
    endtask

    // Accept the held word, then scramble the branch inputs to show they are not resampled
    task automatic accept(input logic [1:0] bt, input logic ub, input logic [63:0] rt);
        brTaken     = bt;
        uncondBr    = ub;
        regTarget   = rt;
        instrAccept = 1'b1;
        tick();
        instrAccept = 1'b0;
        brTaken     = 2'b10;
        uncondBr    = 1'b1;
        regTarget   = 64'hDEAD_BEEF_0000_0000;
        check("acc_req", 64'(imemReq), 64'd1);
    endtask

    initial begin
        reset = 1'b1; imemAck = 1'b0; imemRdata = 32'h0; instrAccept = 1'b0;
        brTaken = 2'b00; uncondBr = 1'b0; regTarget = 64'h0;
        repeat (2) tick();
        check("rst_req", 64'(imemReq), 64'd0);
        check("rst_valid", 64'(instrValid), 64'd0);
        check("rst_err", 64'(fetchErr), 64'd0);
        check("rst_instr", 64'(instr), 64'd0);
        check("rst_pc", pcOut, 64'h0);
        check("rst_p4", pcPlus4, 64'h4);

        reset = 1'b0;
        tick();
        check("idle_exit", 64'(imemReq), 64'd1);

        for (int i = 0; i < 4; i++) begin
            do_fetch("seq", 64'(4 * i), 32'h1000_0000 + 32'(i));
            if (i < 3) accept(2'b00, 1'b0, 64'h0);
        end

        // Spurious acks while holding must not disturb the held word
        imemAck = 1'b1; imemRdata = 32'hFFFF_FFFF;
        repeat (3) tick();
        imemAck = 1'b0;
        check("hold_instr", 64'(instr), 64'h1000_0003);
        check("hold_valid", 64'(instrValid), 64'd1);
        check("hold_pc", pcOut, 64'hC);

        accept(2'b10, 1'b0, 64'h2003);
        do_fetch("reg", 64'h2000, 32'hD61F_0000);
        accept(2'b10, 1'b0, 64'h102);
        do_fetch("b", 64'h100, 32'h17FF_FFFE);
        accept(2'b01, 1'b1, 64'h0);
        do_fetch("b_tgt", 64'hF8, 32'hD503_201F);
        accept(2'b10, 1'b0, 64'h40);
        do_fetch("bc", 64'h40, 32'h5400_0060);
        accept(2'b01, 1'b0, 64'h0);
        do_fetch("bc_tgt", 64'h4C, 32'hD503_201F);
        accept(2'b10, 1'b0, 64'h40);
        do_fetch("bc2", 64'h40, 32'h5400_0060);
        accept(2'b00, 1'b1, 64'h0);
        do_fetch("bc_seq", 64'h44, 32'hD503_201F);
        accept(2'b11, 1'b1, 64'h0);

        // Fetch at 0x48 with ack withheld
        repeat (7) tick();
        check("to_pre_err", 64'(fetchErr), 64'd0);
        check("to_pre_req", 64'(imemReq), 64'd1);
        check("to_pre_addr", imemAddr, 64'h48);
        tick();
        check("to_err", 64'(fetchErr), 64'd1);
        check("to_noreq", 64'(imemReq), 64'd0);
        check("to_novalid", 64'(instrValid), 64'd0);
        imemAck = 1'b1; instrAccept = 1'b1;
        repeat (3) tick();
        imemAck = 1'b0; instrAccept = 1'b0;
        check("err_sticky", 64'(fetchErr), 64'd1);
        check("err_novalid", 64'(instrValid), 64'd0);
        check("err_noreq", 64'(imemReq), 64'd0);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("err_rst_clr", 64'(fetchErr), 64'd0);
        check("err_rst_pc", pcOut, 64'h0);
        tick();

        // Reset mid-FETCH with a coincident ack
        do_fetch("r1", 64'h0, 32'hAAAA_0001);
        accept(2'b00, 1'b0, 64'h0);
        check("r1_addr", imemAddr, 64'h4);
        reset = 1'b1; imemAck = 1'b1; imemRdata = 32'h5555_5555;
        tick();
        reset = 1'b0; imemAck = 1'b0; imemRdata = 32'h0;
        check("rf_novalid", 64'(instrValid), 64'd0);
        check("rf_noreq", 64'(imemReq), 64'd0);
        check("rf_instr", 64'(instr), 64'h0);
        tick();
        check("rf_req", 64'(imemReq), 64'd1);
        check("rf_addr", imemAddr, 64'h0);
        tick();
        check("rf_still", 64'(instrValid), 64'd0);

        // Reset in HOLD wins over a same-cycle accept
        do_fetch("r2", 64'h0, 32'hBBBB_0002);
        reset = 1'b1; instrAccept = 1'b1; brTaken = 2'b10; regTarget = 64'h500;
        tick();
        reset = 1'b0; instrAccept = 1'b0;
        check("rh_pc", pcOut, 64'h0);
        check("rh_novalid", 64'(instrValid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 64'h0, PC value loaded on reset.
REQ-002 Parameter IMEM_TIMEOUT, default 8, ack-wait cycles before fetchErr.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 imemReq  output  1  fetch request to instruction memory.
REQ-006 imemAddr  output  64  fetch address; equals pc while imemReq=1.
REQ-007 imemAck  input  1  memory returns imemRdata this cycle.
REQ-008 imemRdata  input  32  fetched instruction word.
REQ-009 instr  output  32  held instruction; bits [31:21] drive decode opCode.
REQ-010 instrValid  output  1  instr holds a valid fetched word.
REQ-011 instrAccept  input  1  downstream retires instr this cycle.
REQ-012 pcOut  output  64  PC of held instruction.
REQ-013 pcPlus4  output  64  pcOut+4; BL link value for X30.
REQ-014 brTaken  input  2  next-PC select: 00 seq, 01 PC-relative, 10 register, 11 reserved.
REQ-015 uncondBr  input  1  1: offset = instr[25:0]; 0: offset = instr[23:5].
REQ-016 regTarget  input  64  BR target from register file.
REQ-017 fetchErr  output  1  sticky; set on ack timeout.

Function
REQ-018 FSM states SHALL be IDLE, FETCH, HOLD, ERR.
REQ-019 IDLE: one cycle after reset; unconditionally goes to FETCH next cycle.
REQ-020 FETCH: imemReq=1, imemAddr=pc; on imemAck, latch imemRdata into instr and go to HOLD.
REQ-021 imemAck outside FETCH SHALL be ignored.
REQ-022 HOLD: instrValid=1, imemReq=0; instr and pcOut stable until instrAccept.
REQ-023 On HOLD with instrAccept=1, pc SHALL load nextPc and FSM go to FETCH in the same edge.
REQ-024 nextPc: brTaken 00 or 11 -> pc+4; 01 -> pc + (sign-extended offset << 2); 10 -> regTarget with bits [1:0] forced to 0.
REQ-025 brTaken, uncondBr, regTarget SHALL be sampled only in the cycle instrAccept=1 in HOLD.
REQ-026 All PC arithmetic SHALL be 64-bit modulo 2^64; wrap-around is silent.
REQ-027 Minimum instruction throughput SHALL be one instruction per 2 cycles (FETCH with same-cycle ack, then HOLD with immediate accept).
REQ-028 In FETCH, a counter SHALL count cycles without ack; reaching IMEM_TIMEOUT moves FSM to ERR.
REQ-029 ERR: imemReq=0, instrValid=0, fetchErr=1; remains until reset.
REQ-030 pcPlus4 SHALL equal pcOut+4 combinationally in every state.

Reset
REQ-031 On reset=1 at a clock edge: pc=RESET_PC, state=IDLE, instr=0, instrValid=0, imemReq=0, fetchErr=0, timeout counter=0.
REQ-032 Reset asserted mid-FETCH SHALL drop imemReq next cycle; an ack arriving that cycle SHALL be discarded.
REQ-033 Reset SHALL take priority over instrAccept and imemAck in the same cycle.

Structure
REQ-034 Shared package SHALL hold the brTaken encoding enum, the FSM state enum, instruction width (32), and address width (64).
REQ-035 Next-PC arithmetic SHALL be one sub-module, pc_next_calc (combinational: pc, instr, brTaken, uncondBr, regTarget -> nextPc).

Verification
REQ-036 Reset, memory acks every request in 0 cycles -> imemAddr 0,4,8,12 on successive fetches; instrValid pulses each HOLD.
REQ-037 Held instr at pc=0x100 with imm26=-2, uncondBr=1, brTaken=01, accept -> next imemAddr=0xF8.
REQ-038 Held instr at pc=0x40 with imm19=3, uncondBr=0, brTaken=01 -> next imemAddr=0x4C; brTaken=00 -> 0x44.
REQ-039 brTaken=10, regTarget=0x2003 -> next imemAddr=0x2000; pcPlus4 equals pcOut+4 throughout.
REQ-040 Withhold imemAck for 8 cycles -> fetchErr=1, imemReq=0; held until reset, then pc=RESET_PC.
REQ-041 Assert reset during FETCH with simultaneous imemAck -> instrValid stays 0, first post-reset fetch address is RESET_PC.
